// File: rtl/bmd_256_latency_calc.sv
// Latency calculator: reads the send timestamp for each received tag from BRAM,
// subtracts it from the arrival time and accumulates per-window statistics.
module bmd_256_latency_calc #(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      latency_counter,
    input  logic             start,
    input  logic             stats_clear,
    input  logic [CNT_W-1:0] window_len,
    input  logic [63:0]      threshold,
    input  logic             rx_tag_valid,
    input  logic [9:0]       rx_tag,
    output logic             bram_reb,
    output logic [9:0]       bram_rd_addr,
    input  logic [63:0]      bram_rd_data,
    output logic             lat_valid,
    output logic [63:0]      lat_value,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] late_cnt,
    output logic [63:0]      lat_min,
    output logic [63:0]      lat_max,
    output logic [63:0]      lat_sum,
    output logic             busy,
    output logic             done
);

    localparam int PIPE_D = RD_LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  acc_cnt_reg, acc_cnt_next;
    logic              win_open, win_full, win_start, accept;

    logic [PIPE_D-1:0] pipe_valid_reg;
    logic [63:0]       pipe_arr_reg [PIPE_D];

    logic              bram_reb_reg;
    logic [9:0]        bram_rd_addr_reg;
    logic              lat_valid_reg;
    logic [63:0]       lat_value_reg;
    logic [CNT_W-1:0]  sample_cnt_reg, late_cnt_reg;
    logic [63:0]       lat_min_reg, lat_max_reg, lat_sum_reg;

    logic              data_valid;
    logic [63:0]       lat_new;
    logic [64:0]       sum_ext;

    // Requests are counted at acceptance so the window closes without waiting for data
    assign win_open     = (window_len == '0) || (acc_cnt_reg < window_len);
    assign accept       = (state_reg == ST_MEASURE) && rx_tag_valid && win_open && !stats_clear;
    assign acc_cnt_next = acc_cnt_reg + {{(CNT_W-1){1'b0}}, accept};
    assign win_full     = (window_len != '0) && (acc_cnt_next >= window_len);
    assign win_start    = start && !stats_clear &&
                          ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_comb begin
        state_next = state_reg;
        if (stats_clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    if (start)                   state_next = ST_MEASURE;
                ST_MEASURE: if (win_full)                state_next = ST_DRAIN;
                ST_DRAIN:   if (pipe_valid_reg == '0)    state_next = ST_DONE;
                ST_DONE:    if (start)                   state_next = ST_MEASURE;
                default:                                 state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clear || win_start) begin
            acc_cnt_reg <= '0;
        end else begin
            acc_cnt_reg <= acc_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_reb_reg     <= 1'b0;
            bram_rd_addr_reg <= '0;
        end else begin
            bram_reb_reg <= accept;
            if (accept) begin
                bram_rd_addr_reg <= rx_tag;
            end
        end
    end

    // Arrival-time pipe: last stage lines up with the BRAM read data
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_D; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst || stats_clear) begin
                        pipe_valid_reg[0] <= 1'b0;
                    end else begin
                        pipe_valid_reg[0] <= accept;
                    end
                    pipe_arr_reg[0] <= latency_counter;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst || stats_clear) begin
                        pipe_valid_reg[gi] <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    end
                    pipe_arr_reg[gi] <= pipe_arr_reg[gi-1];
                end
            end
        end
    endgenerate

    assign data_valid = pipe_valid_reg[PIPE_D-1];
    assign lat_new    = pipe_arr_reg[PIPE_D-1] - bram_rd_data;
    assign sum_ext    = {1'b0, lat_sum_reg} + {1'b0, lat_new};

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_valid_reg <= 1'b0;
            lat_value_reg <= '0;
        end else begin
            lat_valid_reg <= data_valid && !stats_clear;
            if (data_valid && !stats_clear) begin
                lat_value_reg <= lat_new;
            end
        end
    end

    // Statistics land on the same edge as lat_value so they are visible with lat_valid
    always_ff @(posedge clk) begin
        if (rst || stats_clear || win_start) begin
            sample_cnt_reg <= '0;
            late_cnt_reg   <= '0;
            lat_min_reg    <= '1;
            lat_max_reg    <= '0;
            lat_sum_reg    <= '0;
        end else if (data_valid) begin
            if (sample_cnt_reg != '1) begin
                sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
            if ((lat_new > threshold) && (late_cnt_reg != '1)) begin
                late_cnt_reg <= late_cnt_reg + 1'b1;
            end
            if (lat_new < lat_min_reg) begin
                lat_min_reg <= lat_new;
            end
            if (lat_new > lat_max_reg) begin
                lat_max_reg <= lat_new;
            end
            lat_sum_reg <= sum_ext[64] ? '1 : sum_ext[63:0];
        end
    end

    assign bram_reb     = bram_reb_reg;
    assign bram_rd_addr = bram_rd_addr_reg;
    assign lat_valid    = lat_valid_reg;
    assign lat_value    = lat_value_reg;
    assign sample_cnt   = sample_cnt_reg;
    assign late_cnt     = late_cnt_reg;
    assign lat_min      = lat_min_reg;
    assign lat_max      = lat_max_reg;
    assign lat_sum      = lat_sum_reg;
    assign busy         = (state_reg == ST_MEASURE);
    assign done         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bmd_256_latency_calc.sv
// Bench for bmd_256_latency_calc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_bmd_256_latency_calc;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      latency_counter;
    logic             start;
    logic             stats_clear;
    logic [CNT_W-1:0] window_len;
    logic [63:0]      threshold;
    logic             rx_tag_valid;
    logic [9:0]       rx_tag;
    logic             bram_reb;
    logic [9:0]       bram_rd_addr;
    logic [63:0]      bram_rd_data;
    logic             lat_valid;
    logic [63:0]      lat_value;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] late_cnt;
    logic [63:0]      lat_min;
    logic [63:0]      lat_max;
    logic [63:0]      lat_sum;
    logic             busy;
    logic             done;

    always #2 clk = ~clk;

    bmd_256_latency_calc #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .latency_counter(latency_counter), .start(start),
        .stats_clear(stats_clear), .window_len(window_len), .threshold(threshold),
        .rx_tag_valid(rx_tag_valid), .rx_tag(rx_tag), .bram_reb(bram_reb),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data), .lat_valid(lat_valid),
        .lat_value(lat_value), .sample_cnt(sample_cnt), .late_cnt(late_cnt),
        .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum), .busy(busy), .done(done)
    );

    // Timestamp BRAM, port B with RD_LAT clocks of read latency
    logic [63:0] mem [1024];
    logic [63:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= bram_reb ? mem[bram_rd_addr] : 64'h0BAD_0BAD_0BAD_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rd_data = rd_pipe[RD_LAT-1];

    int vec_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_MEAS, M_DRAIN, M_DONE} mphase_t;
    typedef struct { longint unsigned due; logic [63:0] lat; } pend_t;

    pend_t            pend_q[$];
    longint unsigned  edge_n      = 0;
    mphase_t          m_phase     = M_IDLE;
    int unsigned      m_acc       = 0;
    logic             m_reb       = 1'b0;
    logic [9:0]       m_addr      = '0;
    logic             m_lat_valid = 1'b0;
    logic [63:0]      m_lat_value = '0;
    logic [CNT_W-1:0] m_sample    = '0;
    logic [CNT_W-1:0] m_late      = '0;
    logic [63:0]      m_min       = '1;
    logic [63:0]      m_max       = '0;
    logic [63:0]      m_sum       = '0;

    task automatic clear_model_stats();
        m_sample = '0; m_late = '0; m_min = '1; m_max = '0; m_sum = '0;
    endtask

    always @(posedge clk) begin : model
        mphase_t ph;
        pend_t   p;
        edge_n++;
        ph          = m_phase;
        m_lat_valid = 1'b0;
        m_reb       = 1'b0;
        if (rst || stats_clear) begin
            m_phase = M_IDLE;
            m_acc   = 0;
            pend_q.delete();
            clear_model_stats();
            if (rst) begin
                m_addr      = '0;
                m_lat_value = '0;
            end
        end else begin
            if (ph == M_DRAIN && pend_q.size() == 0) m_phase = M_DONE;
            if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                p = pend_q.pop_front();
                m_lat_valid = 1'b1;
                m_lat_value = p.lat;
                if (m_sample != '1) m_sample = m_sample + 1;
                if (p.lat > threshold && m_late != '1) m_late = m_late + 1;
                if (p.lat < m_min) m_min = p.lat;
                if (p.lat > m_max) m_max = p.lat;
                if (64'hFFFF_FFFF_FFFF_FFFF - m_sum < p.lat) m_sum = '1;
                else m_sum = m_sum + p.lat;
            end
            if ((ph == M_IDLE || ph == M_DONE) && start) begin
                m_phase = M_MEAS;
                m_acc   = 0;
                clear_model_stats();
            end
            if (ph == M_MEAS) begin
                if (rx_tag_valid && (window_len == 0 || m_acc < window_len)) begin
                    m_reb  = 1'b1;
                    m_addr = rx_tag;
                    m_acc++;
                    pend_q.push_back('{due: edge_n + RD_LAT + 1,
                                       lat: latency_counter - mem[rx_tag]});
                end
                if (window_len != 0 && m_acc >= window_len) m_phase = M_DRAIN;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("bram_reb", 64'(bram_reb), 64'(m_reb));
            if (m_reb) check("bram_rd_addr", 64'(bram_rd_addr), 64'(m_addr));
            check("lat_valid", 64'(lat_valid), 64'(m_lat_valid));
            check("lat_value", lat_value, m_lat_value);
            check("sample_cnt", 64'(sample_cnt), 64'(m_sample));
            check("late_cnt", 64'(late_cnt), 64'(m_late));
            check("lat_min", lat_min, m_min);
            check("lat_max", lat_max, m_max);
            check("lat_sum", lat_sum, m_sum);
            check("busy", 64'(busy), 64'(m_phase == M_MEAS));
            check("done", 64'(done), 64'(m_phase == M_DONE));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        start           = 1'b0;
        stats_clear     = 1'b0;
        rx_tag_valid    = 1'b0;
        latency_counter = latency_counter + 64'd1;
    endtask

    initial begin
        logic [63:0] base;
        int unsigned r;

        rst = 1'b1; start = 1'b0; stats_clear = 1'b0; rx_tag_valid = 1'b0; rx_tag = '0;
        latency_counter = '0; window_len = '0; threshold = '1;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_lat_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_bram_reb", 64'(bram_reb), 64'd0);

        // Single sample
        mem[5] = 64'd100; window_len = 1; threshold = '1;
        start = 1'b1; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd5; latency_counter = 64'd130; step();
        check("t1_reb", 64'(bram_reb), 64'd1);
        check("t1_addr", 64'(bram_rd_addr), 64'd5);
        step(); step();
        check("t1_not_early", 64'(lat_valid), 64'd0);
        step();
        check("t1_lat_valid", 64'(lat_valid), 64'd1);
        check("t1_lat_value", lat_value, 64'd30);
        check("t1_sample_cnt", 64'(sample_cnt), 64'd1);
        check("t1_min_max_sum", {lat_min[15:0], lat_max[15:0], lat_sum[15:0]}, 48'h001E_001E_001E);
        check("t1_done_early", 64'(done), 64'd0);
        step();
        check("t1_done", 64'(done), 64'd1);

        // Burst of four plus one ignored extra tag
        mem[10] = 64'd990; mem[11] = 64'd951; mem[12] = 64'd982; mem[13] = 64'd963;
        window_len = 4; threshold = 64'd1000;
        start = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            rx_tag_valid = 1'b1; rx_tag = 10'(10 + i);
            if (i == 0) latency_counter = 64'd1000;
            step();
        end
        check("t2_extra_no_reb", 64'(bram_reb), 64'd0);
        step(); step();
        check("t2_last_valid", 64'(lat_valid), 64'd1);
        check("t2_sample_cnt", 64'(sample_cnt), 64'd4);
        check("t2_done_early", 64'(done), 64'd0);
        step();
        check("t2_done", 64'(done), 64'd1);
        check("t2_min", lat_min, 64'd10);
        check("t2_max", lat_max, 64'd50);
        check("t2_sum", lat_sum, 64'd120);

        // Threshold boundary: 20 is not late, 21 is
        mem[30] = 64'd500; mem[31] = 64'd500; window_len = 2; threshold = 64'd20;
        start = 1'b1; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd30; latency_counter = 64'd520; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd31; step();
        step(); step(); step(); step();
        check("t3_late_cnt", 64'(late_cnt), 64'd1);
        check("t3_done", 64'(done), 64'd1);

        // Counter wrap
        mem[7] = 64'hFFFF_FFFF_FFFF_FFF0; window_len = 1; threshold = '1;
        start = 1'b1; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd7; latency_counter = 64'h10; step();
        step(); step(); step();
        check("t4_wrap", lat_value, 64'h20);
        step();
        check("t4_done", 64'(done), 64'd1);

        // Clear while a read is in flight
        window_len = 3;
        start = 1'b1; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd5; step();
        stats_clear = 1'b1; step();
        for (int i = 0; i < 6; i++) begin
            check("t5_no_lat_valid", 64'(lat_valid), 64'd0);
            step();
        end
        check("t5_sample_cnt", 64'(sample_cnt), 64'd0);
        check("t5_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t5_sum", lat_sum, 64'd0);
        check("t5_idle", {62'd0, busy, done}, 64'd0);
        rx_tag_valid = 1'b1; rx_tag = 10'd5; step();
        check("t5_idle_no_reb", 64'(bram_reb), 64'd0);

        // Sum saturation
        mem[20] = 64'd0; window_len = 3; threshold = 64'd0;
        start = 1'b1; step();
        latency_counter = 64'hC000_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            rx_tag_valid = 1'b1; rx_tag = 10'd20; step();
        end
        step(); step(); step(); step(); step();
        check("t6_sum_sat", lat_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_late_cnt", 64'(late_cnt), 64'd3);
        check("t6_done", 64'(done), 64'd1);
        stats_clear = 1'b1; step();
        rx_tag_valid = 1'b1; rx_tag = 10'd20; step();
        check("t6_idle_no_reb", 64'(bram_reb), 64'd0);

        // Randomized traffic against the model
        base = {$urandom, $urandom};
        latency_counter = base;
        for (int i = 0; i < 512; i++) mem[i] = base - 64'($urandom_range(0, 20000));
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 999);
            rst = (r >= 995);
            stats_clear = (r >= 985 && r < 995);
            start = (r < 40);
            if (start) begin
                window_len = CNT_W'($urandom_range(0, 6));
                threshold  = 64'($urandom_range(0, 25000));
            end
            rx_tag_valid = ($urandom_range(0, 2) != 0);
            rx_tag = 10'($urandom_range(0, 1023));
            step();
            rst = 1'b0;
        end
        for (int i = 0; i < 10; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bmd_256_latency_calc.md
Name: bmd_256_latency_calc

Overview:
- Downstream consumer of the latency-timestamp BRAM read port.
- For each receive-side tag reported by RX_ENGINE:
  - issues a BRAM read at the tag address;
  - captures the free-running latency counter at arrival;
  - subtracts the stored send timestamp when read data returns.
- Accumulates per-window statistics (count, min, max, sum, over-threshold count) over a programmed number of samples. Results are readable by VIO/ILA or the register block.

Parameters:
- RD_LAT, 2, BRAM port-B read latency in clocks. Supported range 1..4.
- CNT_W, 32, width of sample and threshold-exceed counters.

Ports:
- clk  in  1  250 MHz user clock, shared with the BRAM and latency counter.
- rst  in  1  synchronous, active-high reset.
- latency_counter  in  64  free-running timestamp counter.
- start  in  1  pulse; arms a new measurement window.
- stats_clear  in  1  pulse; clears statistics, returns to IDLE.
- window_len  in  CNT_W  samples per window. 0 means unbounded.
- threshold  in  64  latency above which a sample counts as late.
- rx_tag_valid  in  1  RX_ENGINE received a tagged packet this cycle.
- rx_tag  in  10  BRAM address that holds the send timestamp.
- bram_reb  out  1  BRAM port-B enable.
- bram_rd_addr  out  10  BRAM port-B address.
- bram_rd_data  in  64  BRAM port-B data, valid RD_LAT clocks after bram_reb.
- lat_valid  out  1  one-cycle pulse; lat_value is new.
- lat_value  out  64  latest computed latency.
- sample_cnt  out  CNT_W  samples accumulated in the current window.
- late_cnt  out  CNT_W  samples with latency > threshold.
- lat_min  out  64  minimum latency in the window.
- lat_max  out  64  maximum latency in the window.
- lat_sum  out  64  saturating sum of latencies.
- busy  out  1  state is MEASURE.
- done  out  1  state is DONE.

Behaviour:
- Reset values:
  - bram_reb=0, bram_rd_addr=0, lat_valid=0, lat_value=0.
  - All counters 0, lat_sum=0, lat_max=0, lat_min=all-ones.
  - busy=0, done=0, state IDLE.
- FSM states: IDLE, MEASURE, DRAIN, DONE.
  - IDLE: start -> MEASURE. Statistics are cleared on the same edge as the transition.
  - MEASURE: when the accepted-request count reaches window_len (window_len≠0) -> DRAIN.
  - DRAIN: when the pipeline is empty -> DONE.
  - DONE: holds results. start -> MEASURE with stats cleared.
  - stats_clear in any state: -> IDLE, stats reset, pipeline flushed. stats_clear has priority over start.
- Request stage:
  - A request is accepted only in MEASURE, and only while accepted requests < window_len (or window_len=0).
  - On an accepted request: bram_reb=1 and bram_rd_addr=rx_tag, both registered, so they appear 1 clock after rx_tag_valid.
  - latency_counter is sampled in the same cycle as rx_tag_valid. This arrival time travels in a valid/data shift pipe of depth 1+RD_LAT.
  - Back-to-back requests are accepted every clock; there is no backpressure.
  - rx_tag_valid outside MEASURE is ignored: no BRAM read.
- Compute stage:
  - Data is valid when the pipe output valid bit is set, RD_LAT clocks after bram_reb.
  - lat = arrival - bram_rd_data, modulo 2^64, so counter wrap-around gives the correct small value.
  - lat_value and lat_valid are registered 1 clock after the data is valid.
  - Total rx_tag_valid -> lat_valid latency = RD_LAT+2 clocks.
- Statistics are updated on the lat_valid cycle:
  - sample_cnt+1, saturating at all-ones.
  - late_cnt+1 if lat > threshold; strictly greater, so equal is not late.
  - min/max compare against the new sample.
  - lat_sum adds the sample, saturating at 2^64-1.
- Window end:
  - DRAIN lasts until the last in-flight sample retires.
  - done asserts the cycle after the final stats update.
- Mid-operation events:
  - start while MEASURE or DRAIN is ignored.
  - stats_clear while reads are in flight discards all in-flight results; no lat_valid follows.
  - rst behaves identically to stats_clear and also restores reset values.

Test Plan:
- Single sample: RD_LAT=2, window_len=1, start. BRAM[5]=100. rx_tag=5 at latency_counter=130. -> bram_reb 1 clk later with addr 5; lat_valid 4 clks after rx_tag_valid with lat_value=30; sample_cnt=1, min=max=sum=30; done next clk.
- Burst: window_len=4, four back-to-back tags with latencies 10, 50, 20, 40. -> four consecutive lat_valid pulses; min=10, max=50, sum=120; done only after the 4th update; a 5th rx_tag_valid produces no bram_reb.
- Threshold boundary: threshold=20, latencies 20 and 21. -> late_cnt=1.
- Wrap: timestamp=0xFFFF_FFFF_FFFF_FFF0, arrival=0x10. -> lat_value=0x20.
- Clear mid-flight: stats_clear one clock after rx_tag_valid. -> no lat_valid; stats at reset values; state IDLE; subsequent rx_tag_valid gives no bram_reb.
- Saturation and idle gating: preload lat_sum near max with large latencies -> lat_sum sticks at 2^64-1. rx_tag_valid while in IDLE -> bram_reb stays 0.
